pool2x2_stream: RTL and testbench

Parametrised streaming 2x2 / stride-2 pooling engine with max and average modes. It sits between the convolution output stream and the feature-map write-back. It consumes one pixel per cycle in row-major order over a valid/ready handshake and buffers one row of horizontal partial results. It emits each pooled pixel with its write-back address and pulses `done` at frame end.

---
 rtl/pool2x2_stream.sv | 176 +++++++++++++++++
 tb/tb_pool2x2_stream.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 max/average pooling engine with one-row line buffer.
// Emits pooled pixels with write-back addresses and pulses done at frame end.
module pool2x2_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pool_type,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int LB_D  = IMG_W / 2;
  localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;
  localparam int TOTAL = (IMG_W / 2) * (IMG_H / 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                in_done_q, in_done_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;

  logic [DATA_W:0]     lb_q [LB_D];
  logic [LB_AW-1:0]    lb_idx;
  logic [DATA_W:0]     lb_rdata;
  logic                lb_we;

  logic                accept, out_hs, last_hs, load;
  logic [DATA_W:0]     pair;
  logic [DATA_W+1:0]   comb_sum;
  logic [DATA_W-1:0]   comb_res;

  assign in_ready  = (state_q == RUN) & (~out_valid_q | out_ready) & ~in_done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

  assign lb_idx   = LB_AW'(col_q >> 1);
  assign lb_rdata = lb_q[lb_idx];

  // Datapath: horizontal pair, then vertical combine with the buffered pair.
  always_comb begin
    accept  = in_valid & in_ready;
    out_hs  = out_valid_q & out_ready;
    last_hs = out_hs & (out_addr_q == ADDR_W'(TOTAL - 1));
    load    = accept & col_q[0] & row_q[0];
    lb_we   = accept & col_q[0] & ~row_q[0];

    if (mode_q) begin
      pair = {1'b0, hold_q} + {1'b0, in_data};
    end else begin
      pair = {1'b0, (hold_q > in_data) ? hold_q : in_data};
    end

    comb_sum = {1'b0, lb_rdata} + {1'b0, pair};
    if (mode_q) begin
      comb_res = comb_sum[DATA_W+1:2];
    end else begin
      comb_res = (lb_rdata[DATA_W-1:0] > pair[DATA_W-1:0]) ?
                 lb_rdata[DATA_W-1:0] : pair[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    in_done_d   = in_done_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          mode_d     = pool_type;
          col_d      = '0;
          row_d      = '0;
          in_done_d  = 1'b0;
          out_addr_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (!col_q[0]) begin
            hold_d = in_data;
          end
          if (col_q == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            if (row_q == ROW_W'(IMG_H - 1)) begin
              in_done_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        // Address stays on the final output so it reads TOTAL-1 after the frame.
        if (out_hs && !last_hs) begin
          out_addr_d = out_addr_q + 1'b1;
        end
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = comb_res;
        end else if (out_hs) begin
          out_valid_d = 1'b0;
        end
        if (last_hs) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      in_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      in_done_q   <= in_done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_idx] <= pair;
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream: a 4x4 and a default 26x26 instance share stimulus,
// results are checked through an expected-output queue.
module tb_pool2x2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, pool_type, in_valid, out_ready, sel;
  logic [7:0] in_data;

  logic       start4, start26;
  logic       in_ready4, ov4, busy4, done4;
  logic [7:0] od4;
  logic [3:0] oa4;
  logic       in_ready26, ov26, busy26, done26;
  logic [7:0] od26, oa26;

  logic       in_ready, out_valid, busy, done;
  logic [7:0] out_data, out_addr;

  assign start4    = start & ~sel;
  assign start26   = start & sel;
  assign in_ready  = sel ? in_ready26 : in_ready4;
  assign out_valid = sel ? ov26 : ov4;
  assign out_data  = sel ? od26 : od4;
  assign out_addr  = sel ? oa26 : {4'b0, oa4};
  assign busy      = sel ? busy26 : busy4;
  assign done      = sel ? done26 : done4;

  pool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .ADDR_W(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .pool_type(pool_type),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(ov4), .out_data(od4), .out_addr(oa4), .out_ready(out_ready),
    .busy(busy4), .done(done4)
  );

  pool2x2_stream u26 (
    .clk(clk), .rst(rst), .start(start26), .pool_type(pool_type),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready26),
    .out_valid(ov26), .out_data(od26), .out_addr(oa26), .out_ready(out_ready),
    .busy(busy26), .done(done26)
  );

  typedef struct {
    logic [7:0] d;
    logic [7:0] a;
  } exp_t;

  exp_t       q[$];
  logic [7:0] img [676];
  int         errors = 0;
  int         checks = 0;

  function automatic void push_exp(input int d, input int a);
    exp_t e;
    e.d = 8'(d);
    e.a = 8'(a);
    q.push_back(e);
  endfunction

  function automatic void push_model(input int w, input int h, input bit mode);
    for (int br = 0; br < h / 2; br++) begin
      for (int bc = 0; bc < w / 2; bc++) begin
        int i, a, b, c, d, v;
        i = 2 * br * w + 2 * bc;
        a = int'(img[i]);     b = int'(img[i + 1]);
        c = int'(img[i + w]); d = int'(img[i + w + 1]);
        if (mode) begin
          v = (a + b + c + d) / 4;
        end else begin
          v = a;
          if (b > v) v = b;
          if (c > v) v = c;
          if (d > v) v = d;
        end
        push_exp(v, br * (w / 2) + bc);
      end
    end
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < 676; i++) img[i] = 8'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 676; i++) img[i] = 8'($urandom);
  endtask

  // Runs one frame; expected results must already be queued.
  task automatic run_frame(input int w, input int h, input bit mode,
                           input int pr_ready, input int pr_valid,
                           input bit toggle_mode, input bit mid_start,
                           input string name);
    int n, total, pix, hs, cyc, r, c;
    bit finished, done_next, exp_ov_next, stalled;
    logic [7:0] st_d, st_a;
    exp_t e;
    n = w * h; total = (w / 2) * (h / 2);
    pix = 0; hs = 0; finished = 0; done_next = 0; exp_ov_next = 0; stalled = 0;
    st_d = '0; st_a = '0;
    sel = (w == 26);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: in_ready=%b busy=%b, required 0 0", name, in_ready, busy);
    end
    start = 1'b1; pool_type = mode;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start: in_ready=%b busy=%b, required 1 1", name, in_ready, busy);
    end
    for (cyc = 0; cyc < 20000 && !finished; cyc++) begin
      in_valid  = (pix < n) && ($urandom_range(99) < 32'(pr_valid));
      in_data   = (pix < n) ? img[pix] : 8'($urandom);
      out_ready = ($urandom_range(99) < 32'(pr_ready));
      if (toggle_mode) pool_type = 1'($urandom);
      start = (mid_start && cyc == 5);
      @(negedge clk);
      if (exp_ov_next) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s latency: out_valid=%b, required 1", name, out_valid);
        end
      end
      exp_ov_next = 0;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== st_d || out_addr !== st_a) begin
          errors++;
          $display("FAIL %s hold: valid=%b data=%0d addr=%0d, required 1 %0d %0d",
                   name, out_valid, out_data, out_addr, st_d, st_a);
        end
      end
      checks++;
      if (done_next) begin
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL %s done_pulse: done=%b, required 1", name, done);
        end
        finished = 1;
      end else if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s early_done: done=%b, required 0", name, done);
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_blocks_input: in_ready=%b, required 0", name, in_ready);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_output: data=%0d addr=%0d, required none", name, out_data, out_addr);
        end else begin
          e = q.pop_front();
          if (out_data !== e.d || out_addr !== e.a) begin
            errors++;
            $display("FAIL %s output: data=%0d addr=%0d, required %0d %0d",
                     name, out_data, out_addr, e.d, e.a);
          end
        end
        hs++;
        if (hs == total) done_next = 1;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      st_d = out_data; st_a = out_addr;
      if (in_valid && in_ready === 1'b1) begin
        r = pix / w; c = pix % w;
        if ((r % 2 == 1) && (c % 2 == 1)) exp_ov_next = 1;
        pix++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: outputs=%0d, required %0d", name, hs, total);
    end else if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
                 out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_idle: done=%b busy=%b in_ready=%b out_valid=%b, required 0 0 0 0",
               name, done, busy, in_ready, out_valid);
    end
    checks++;
    if (q.size() != 0 || pix != n || out_addr !== 8'(total - 1)) begin
      errors++;
      $display("FAIL %s frame_end: left=%0d pixels=%0d addr=%0d, required 0 %0d %0d",
               name, q.size(), pix, out_addr, n, total - 1);
    end
    q.delete();
  endtask

  task automatic check_reset_values(input string name);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'd0 ||
          out_addr !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s sel=%0d: rdy=%b ov=%b data=%0d addr=%0d busy=%b done=%b, required all 0",
                 name, s, in_ready, out_valid, out_data, out_addr, busy, done);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset();
    check_reset_values("reset_state");
  endtask

  task automatic test_max4();
    fill_ramp();
    push_exp(5, 0); push_exp(7, 1); push_exp(13, 2); push_exp(15, 3);
    run_frame(4, 4, 1'b0, 100, 100, 1'b0, 1'b0, "max4");
  endtask

  task automatic test_avg4();
    fill_ramp();
    push_exp(2, 0); push_exp(4, 1); push_exp(10, 2); push_exp(12, 3);
    run_frame(4, 4, 1'b1, 100, 100, 1'b0, 1'b0, "avg4");
  endtask

  task automatic test_avg_edge();
    // Blocks {1,2,2,2}, {255 x4}, {0 x4}, {0,0,0,3}.
    for (int i = 0; i < 16; i++) img[i] = 8'd0;
    img[0] = 8'd1; img[1] = 8'd2; img[4] = 8'd2; img[5] = 8'd2;
    img[2] = 8'd255; img[3] = 8'd255; img[6] = 8'd255; img[7] = 8'd255;
    img[15] = 8'd3;
    push_exp(1, 0); push_exp(255, 1); push_exp(0, 2); push_exp(0, 3);
    run_frame(4, 4, 1'b1, 100, 100, 1'b0, 1'b0, "avg_edge");
  endtask

  task automatic test_backpressure();
    fill_random();
    push_model(4, 4, 1'b0);
    run_frame(4, 4, 1'b0, 50, 70, 1'b0, 1'b0, "bp_max4");
    push_model(4, 4, 1'b1);
    run_frame(4, 4, 1'b1, 50, 70, 1'b0, 1'b0, "bp_avg4");
    push_model(26, 26, 1'b1);
    run_frame(26, 26, 1'b1, 50, 70, 1'b0, 1'b0, "bp_avg26");
  endtask

  task automatic test_mode_toggle();
    fill_random();
    push_model(4, 4, 1'b1);
    run_frame(4, 4, 1'b1, 100, 100, 1'b1, 1'b1, "toggle_avg4");
    push_model(4, 4, 1'b0);
    run_frame(4, 4, 1'b0, 70, 80, 1'b1, 1'b1, "toggle_max4");
  endtask

  task automatic test_reset_mid();
    int acc;
    fill_ramp();
    sel = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; pool_type = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 100 && acc < 9; cyc++) begin
      in_valid = 1'b1; in_data = img[acc];
      @(negedge clk);
      if (in_ready === 1'b1) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 9) begin
      errors++;
      $display("FAIL reset_mid accept: accepted=%0d, required 9", acc);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    check_reset_values("reset_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(5, 0); push_exp(7, 1); push_exp(13, 2); push_exp(15, 3);
    run_frame(4, 4, 1'b0, 100, 100, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_full_frame();
    fill_random();
    push_model(26, 26, 1'b0);
    run_frame(26, 26, 1'b0, 100, 100, 1'b0, 1'b0, "full_max26");
    fill_random();
    push_model(26, 26, 1'b1);
    run_frame(26, 26, 1'b1, 100, 100, 1'b0, 1'b0, "full_avg26");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pool_type = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1; sel = 1'b0;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_max4();
    test_avg4();
    test_avg_edge();
    test_backpressure();
    test_mode_toggle();
    test_reset_mid();
    test_full_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
